// File: rtl/pio_cmd_responder.sv
// pio_cmd_responder: executes HPS PIO commands against a local byte memory
// and returns a result byte plus done/busy/error flags over a level handshake.
module pio_cmd_responder #(
   parameter int DEPTH       = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [17:0] cmd_word,
   input  logic        cmd_req,
   output logic [7:0]  rsp_data,
   output logic [2:0]  rsp_status
);

   typedef enum logic [1:0] {IDLE, EXEC, SWEEP, DONE} state_t;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_READ  = 3'd2;
   localparam logic [2:0] OP_ADD   = 3'd3;
   localparam logic [2:0] OP_FILL  = 3'd4;
   localparam logic [2:0] OP_SUM   = 3'd5;
   localparam logic [6:0] LAST_IDX = 7'(DEPTH - 1);
   localparam logic [7:0] DEPTH_W  = 8'(DEPTH);

   state_t                 r_state;
   state_t                 w_nextState;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [2:0]             r_op;
   logic [6:0]             r_addr;
   logic [7:0]             r_dat;
   logic [6:0]             r_idx;
   logic [7:0]             r_acc;
   logic [7:0]             r_rspData;
   logic                   r_error;
   logic [7:0]             r_mem [DEPTH];

   logic                   w_reqS;
   logic                   w_addrOk;
   logic                   w_memWe;
   logic [6:0]             w_memAddr;
   logic [7:0]             w_memWdata;
   logic [7:0]             w_memRdata;
   logic [7:0]             w_sweepRdata;

   // cmd_req is asynchronous; only the last synchroniser stage is trusted.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], cmd_req};
      end
   end

   assign w_reqS       = r_sync[SYNC_STAGES-1];
   assign w_addrOk     = ({1'b0, r_addr} < DEPTH_W);
   assign w_memRdata   = r_mem[r_addr];
   assign w_sweepRdata = r_mem[r_idx];

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_reqS) w_nextState = EXEC;
         EXEC:    w_nextState = (r_op == OP_FILL || r_op == OP_SUM) ? SWEEP : DONE;
         SWEEP:   if (r_idx == LAST_IDX) w_nextState = DONE;
         DONE:    if (!w_reqS) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Single write port shared by WRITE/ADD in EXEC and FILL during the sweep.
   always_comb begin
      w_memWe    = 1'b0;
      w_memAddr  = r_addr;
      w_memWdata = r_dat;
      if (r_state == EXEC && w_addrOk) begin
         if (r_op == OP_WRITE) begin
            w_memWe = 1'b1;
         end else if (r_op == OP_ADD) begin
            w_memWe    = 1'b1;
            w_memWdata = w_memRdata + r_dat;
         end
      end else if (r_state == SWEEP && r_op == OP_FILL) begin
         w_memWe   = 1'b1;
         w_memAddr = r_idx;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (w_memWe) begin
         r_mem[w_memAddr] <= w_memWdata;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_op      <= '0;
         r_addr    <= '0;
         r_dat     <= '0;
         r_idx     <= '0;
         r_acc     <= '0;
         r_rspData <= '0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_reqS) begin
                  {r_op, r_addr, r_dat} <= cmd_word;
                  r_error               <= 1'b0;
               end
            end
            EXEC: begin
               r_idx <= '0;
               r_acc <= '0;
               case (r_op)
                  OP_NOP: r_rspData <= 8'h00;
                  OP_WRITE, OP_READ, OP_ADD: begin
                     if (!w_addrOk) begin
                        r_error   <= 1'b1;
                        r_rspData <= 8'h00;
                     end else if (r_op == OP_WRITE) begin
                        r_rspData <= r_dat;
                     end else if (r_op == OP_READ) begin
                        r_rspData <= w_memRdata;
                     end else begin
                        r_rspData <= w_memRdata + r_dat;
                     end
                  end
                  OP_FILL, OP_SUM: ;
                  default: begin
                     r_error   <= 1'b1;
                     r_rspData <= 8'h00;
                  end
               endcase
            end
            SWEEP: begin
               r_idx <= r_idx + 7'd1;
               r_acc <= r_acc + w_sweepRdata;
               if (r_idx == LAST_IDX) begin
                  r_rspData <= (r_op == OP_FILL) ? r_dat : (r_acc + w_sweepRdata);
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_data   = r_rspData;
   assign rsp_status = {r_error, (r_state == EXEC || r_state == SWEEP), (r_state == DONE)};

endmodule

// File: doc/pio_cmd_responder.md
Name: pio_cmd_responder

Overview:
FPGA-side responder for the HPS-to-fabric PIO command channel inside soc_system. HPS software drives an 18-bit command word and a 1-bit request level. This block executes the command against a local byte memory and returns an 8-bit result plus 3 status flags through the input PIOs. Transfers use a 4-phase level handshake, so software polls status and no interrupt is needed.

Parameters:
DEPTH, 128, number of 8-bit memory locations; legal range 1..128, since the address field is 7 bits.
SYNC_STAGES, 2, synchroniser flops on cmd_req; legal range >= 2.

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
cmd_word  in  18  command from pio_2: [17:15] opcode, [14:8] addr, [7:0] data; quasi-static, stable before cmd_req rises
cmd_req  in  1  request level from pio_3; asynchronous to clk_clk
rsp_data  out  8  result byte to pio_0
rsp_status  out  3  to pio_1: [0] done, [1] busy, [2] error

Behaviour:
- Reset (async assert, sync deassert is external): FSM=IDLE, rsp_data=0x00, rsp_status=3'b000, sync chain=0. Memory array is not reset; contents are undefined until written or FILLed.
- cmd_req passes through SYNC_STAGES flops and becomes req_s. cmd_word is not synchronised; it is captured only in IDLE when req_s=1.
- FSM states:
  - IDLE: when req_s=1, capture cmd_word into op/addr/dat and go to EXEC; busy=1 and error=0 from the next cycle.
  - EXEC: decode the opcode.
    - Single-cycle ops: execute, then go to DONE.
    - FILL/SUM: clear the index counter and accumulator, then go to SWEEP.
  - SWEEP: one location per cycle, index 0..DEPTH-1. At index DEPTH-1, finish and go to DONE.
  - DONE: done=1, busy=0. Hold rsp_data and error. When req_s=0, go to IDLE and done=0; rsp_data and error hold until the next capture.
- Opcodes:
  - 0 NOP: rsp_data=0x00.
  - 1 WRITE: mem[addr]=data; rsp_data=data.
  - 2 READ: rsp_data=mem[addr].
  - 3 ADD: mem[addr]=(mem[addr]+data) mod 256; rsp_data=new value; carry is discarded.
  - 4 FILL: mem[i]=data for all i; takes DEPTH cycles; rsp_data=data.
  - 5 SUM: rsp_data=sum of mem[0..DEPTH-1] mod 256; takes DEPTH cycles; memory unchanged.
  - 6, 7: illegal; error=1, rsp_data=0x00, no side effects.
- Address check: for ops 1-3, addr >= DEPTH gives error=1, rsp_data=0x00, no memory write. addr is ignored for ops 0, 4, 5.
- Latency: count from the first clk_clk edge that samples cmd_req=1.
  - Single-cycle ops: done visible after edge SYNC_STAGES+2 (4 with defaults).
  - FILL/SUM: done visible after edge SYNC_STAGES+2+DEPTH.
- done is de-asserted SYNC_STAGES+1 edges after cmd_req falls.
- Each cmd_req high phase executes exactly one command. Holding cmd_req high in DONE never re-executes.
- busy and done are never both 1. error is only meaningful while done=1.
- A cmd_req pulse shorter than SYNC_STAGES cycles may be missed; software must hold cmd_req until done=1.
- Changing cmd_word while busy or done has no effect.
- Reset mid-SWEEP: FSM returns to IDLE; memory keeps whatever partial FILL was written.
- rsp_data and rsp_status are registered, with no combinational path from inputs.

Test Plan:
- Reset: hold reset_reset_n=0 with cmd_req=1 -> rsp_status=000, rsp_data=0x00. Release -> command executes, done after 4 edges.
- WRITE then READ:
  - cmd_word=18'b001_0000101_10100101 (WRITE addr 5, data 0xA5) with handshake -> rsp_data=0xA5, status=001 at edge 4. Drop cmd_req -> status=000 after 3 edges.
  - READ addr 5 -> rsp_data=0xA5.
- ADD wrap: WRITE addr 10 data 0xF0, then ADD addr 10 data 0x20 -> rsp_data=0x10, error=0. READ addr 10 -> 0x10.
- FILL/SUM with DEPTH=128:
  - FILL data 0x03 -> busy=1 for 129 cycles, done at edge 132.
  - SUM -> rsp_data=(128*3) mod 256=0x80.
  - WRITE addr 0 data 0x05, then SUM -> 0x82.
- Errors: opcode 7 -> status=101, rsp_data=0x00. With DEPTH=64, WRITE addr 64 -> error=1, and READ addr 64 also flags error.
- Reset mid-operation: with DEPTH=128, FILL 0xFF from a memory pre-filled with 0x00, then assert reset 20 cycles into SWEEP -> status=000 immediately. SUM afterwards -> rsp_data equals 0xFF times the number of locations written before reset (within the 0..19 window), mod 256. A held cmd_req executes no second command.
